register_renaming: RTL and testbench

Register alias table plus free tag list for the P6-style Tomasulo front end. Each cycle it translates an instruction's two architectural source registers and one destination register into 5-bit rename tags. It allocates a fresh tag for the destination and reports whether each source is still in flight. Committed tags return to the free list and release their architectural mapping.

---
 rtl/register_renaming.sv | 171 +++++++++++++++++
 tb/tb_register_renaming.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/register_renaming.sv
`default_nettype none
// ============================================================================
// Module   : register_renaming
// Purpose  : Register alias table plus free tag list for a Tomasulo-style
//            front end. Translates the two source and one destination
//            architectural registers of an instruction into rename tags,
//            allocates a fresh tag for the destination, and reports whether
//            each source is still in flight. Committed tags return to the
//            free list and release their architectural mapping.
// Ports    : clk             - single clock, rising edge
//            reset           - synchronous, active-low
//            arch_reg        - {src1, src2, dest} architectural indices
//            assign_flag     - rename request for arch_reg this cycle
//            return_flag     - commit: return commit_phys_reg this cycle
//            commit_phys_reg - tag being retired
//            phys_reg        - {src1, src1_ready, src2, src2_ready,
//                               dest, dest_valid}, combinational
// Revision : 1.0 - initial release
// ============================================================================
module register_renaming #(
    parameter int REG_ADDR_LEN = 5,
    parameter int NUM_TAGS     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [3*REG_ADDR_LEN-1:0] arch_reg,
    input  logic                      assign_flag,
    input  logic                      return_flag,
    input  logic [REG_ADDR_LEN-1:0]   commit_phys_reg,
    output logic [3*REG_ADDR_LEN+2:0] phys_reg
);

    localparam int C_W        = REG_ADDR_LEN;
    localparam int C_NUM_ARCH = 1 << REG_ADDR_LEN;
    localparam int C_CNT_W    = $clog2(NUM_TAGS + 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic               r_busy  [C_NUM_ARCH];
    logic [C_W-1:0]     r_tag   [C_NUM_ARCH];
    logic [C_W-1:0]     r_fifo  [NUM_TAGS];
    logic [C_W-1:0]     r_head;
    logic [C_W-1:0]     r_tail;
    logic [C_CNT_W-1:0] r_count;
    logic [NUM_TAGS-1:0] r_alloc;

    // ------------------------------------------------------------------
    // Decoded inputs
    // ------------------------------------------------------------------
    logic [C_W-1:0] w_src1;
    logic [C_W-1:0] w_src2;
    logic [C_W-1:0] w_dest;

    assign w_src1 = arch_reg[3*C_W-1:2*C_W];
    assign w_src2 = arch_reg[2*C_W-1:C_W];
    assign w_dest = arch_reg[C_W-1:0];

    // Allocation decisions use pre-commit state only, so a tag freed in
    // this cycle cannot be handed out until the next cycle.
    logic           w_pop;
    logic           w_push;
    logic [C_W-1:0] w_alloc_tag;

    assign w_pop       = assign_flag && (w_dest != '0) && (r_count != '0);
    // The allocated bitmap filters duplicate or stale commits.
    assign w_push      = return_flag && r_alloc[commit_phys_reg];
    assign w_alloc_tag = r_fifo[r_head];

    // ------------------------------------------------------------------
    // Source lookup with same-cycle commit bypass
    // ------------------------------------------------------------------
    logic           w_src1_busy;
    logic           w_src2_busy;
    logic [C_W-1:0] w_src1_tag;
    logic [C_W-1:0] w_src2_tag;
    logic           w_src1_rdy;
    logic           w_src2_rdy;

    always_comb begin
        w_src1_busy = r_busy[w_src1] && (w_src1 != '0);
        w_src2_busy = r_busy[w_src2] && (w_src2 != '0);
        w_src1_tag  = w_src1;
        w_src2_tag  = w_src2;
        w_src1_rdy  = 1'b1;
        w_src2_rdy  = 1'b1;
        if (w_src1_busy) begin
            w_src1_tag = r_tag[w_src1];
            w_src1_rdy = return_flag && (commit_phys_reg == r_tag[w_src1]);
        end
        if (w_src2_busy) begin
            w_src2_tag = r_tag[w_src2];
            w_src2_rdy = return_flag && (commit_phys_reg == r_tag[w_src2]);
        end
    end

    always_comb begin
        phys_reg = '0;
        if (reset) begin
            phys_reg = {w_src1_tag, w_src1_rdy,
                        w_src2_tag, w_src2_rdy,
                        (w_pop ? w_alloc_tag : {C_W{1'b0}}), w_pop};
        end
    end

    // ------------------------------------------------------------------
    // Pointer arithmetic (explicit wrap so NUM_TAGS need not fill C_W)
    // ------------------------------------------------------------------
    logic [C_W-1:0] w_head_nxt;
    logic [C_W-1:0] w_tail_nxt;

    assign w_head_nxt = (r_head == C_W'(NUM_TAGS - 1)) ? '0 : r_head + 1'b1;
    assign w_tail_nxt = (r_tail == C_W'(NUM_TAGS - 1)) ? '0 : r_tail + 1'b1;

    // ------------------------------------------------------------------
    // Map table
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < C_NUM_ARCH; i++) begin
                r_busy[i] <= 1'b0;
                r_tag[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < C_NUM_ARCH; i++) begin
                // The new mapping from this cycle's assign overrides a
                // release of the same arch register by this cycle's commit.
                if (w_pop && (w_dest == C_W'(i))) begin
                    r_busy[i] <= 1'b1;
                    r_tag[i]  <= w_alloc_tag;
                end else if (w_push && r_busy[i] && (r_tag[i] == commit_phys_reg)) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Free-list FIFO and allocated bitmap
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                r_fifo[i] <= C_W'(i);
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= C_CNT_W'(NUM_TAGS);
            r_alloc <= '0;
        end else begin
            if (w_pop) begin
                r_head               <= w_head_nxt;
                r_alloc[w_alloc_tag] <= 1'b1;
            end
            if (w_push) begin
                r_fifo[r_tail]           <= commit_phys_reg;
                r_tail                   <= w_tail_nxt;
                // The popped tag was free, so it can never equal a valid
                // commit tag; the two bitmap writes never collide.
                r_alloc[commit_phys_reg] <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_register_renaming.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_renaming
// Purpose  : Scoreboarded bench for register_renaming. A driver applies
//            directed and random rename/commit traffic, computes the
//            expected phys_reg from a queue/array reference model and
//            pushes it; a monitor pops and compares on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_renaming;

    logic        clk;
    logic        reset;
    logic [14:0] arch_reg;
    logic        assign_flag;
    logic        return_flag;
    logic [4:0]  commit_phys_reg;
    logic [17:0] phys_reg;

    register_renaming #(.REG_ADDR_LEN(5), .NUM_TAGS(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .arch_reg       (arch_reg),
        .assign_flag    (assign_flag),
        .return_flag    (return_flag),
        .commit_phys_reg(commit_phys_reg),
        .phys_reg       (phys_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] v;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   step_id = 0;

    // Reference model: map_of[r] = tag currently naming arch r, or -1.
    // Free tags live in an ordered queue; "allocated" means "not in it".
    int map_of[32];
    int free_q[$];

    function automatic bit is_free(input int t);
        foreach (free_q[k]) if (free_q[k] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_reset();
        free_q.delete();
        for (int t = 0; t < 32; t++) free_q.push_back(t);
        for (int r = 0; r < 32; r++) map_of[r] = -1;
    endfunction

    // Returns a randomly chosen tag that is currently in flight, or -1.
    function automatic int pick_inflight();
        int cand[$];
        for (int t = 0; t < 32; t++) if (!is_free(t)) cand.push_back(t);
        if (cand.size() == 0) return -1;
        return cand[$urandom_range(cand.size() - 1)];
    endfunction

    task automatic step(input bit rst_n, input bit a, input bit r,
                        input int s1, input int s2, input int d, input int c);
        exp_t e;
        logic [4:0] t1, t2, dt;
        logic       r1, r2, dv;
        bit         ok_commit;
        @(posedge clk);
        #1;
        reset           = rst_n;
        assign_flag     = a;
        return_flag     = r;
        arch_reg        = {5'(s1), 5'(s2), 5'(d)};
        commit_phys_reg = 5'(c);
        step_id++;
        e.id = step_id;
        if (!rst_n) begin
            e.v = '0;
            model_reset();
        end else begin
            // Sources: in flight -> tag, ready only if committed this cycle.
            if (map_of[s1] >= 0) begin
                t1 = 5'(map_of[s1]); r1 = r && (c == map_of[s1]);
            end else begin
                t1 = 5'(s1); r1 = 1'b1;
            end
            if (map_of[s2] >= 0) begin
                t2 = 5'(map_of[s2]); r2 = r && (c == map_of[s2]);
            end else begin
                t2 = 5'(s2); r2 = 1'b1;
            end
            dv = a && (d != 0) && (free_q.size() != 0);
            dt = dv ? 5'(free_q[0]) : 5'd0;
            e.v = {t1, r1, t2, r2, dt, dv};
            // Next state: commit first, then the assign overrides.
            ok_commit = r && !is_free(c);
            if (dv) void'(free_q.pop_front());
            if (ok_commit) begin
                free_q.push_back(c);
                for (int k = 0; k < 32; k++) if (map_of[k] == c) map_of[k] = -1;
            end
            if (dv) map_of[d] = dt;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: the DUT output is valid every cycle after the driver moves.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (phys_reg !== e.v) begin
                bad++;
                $display("FAIL step%0d phys_reg got=%h want=%h", e.id, phys_reg, e.v);
            end
        end
    end

    initial begin
        int c;
        reset           = 1'b0;
        assign_flag     = 1'b0;
        return_flag     = 1'b0;
        arch_reg        = '0;
        commit_phys_reg = '0;
        model_reset();

        // Reset: output forced to zero regardless of request inputs.
        step(0, 1, 1, 3, 4, 5, 6);
        step(0, 0, 0, 0, 0, 0, 0);

        // Back-to-back renames: tags 0,1,2 with dependent sources.
        step(1, 1, 0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 1, 2, 0);
        step(1, 1, 0, 1, 2, 3, 0);

        // Commit 1 and 2, then sources 2,3 become ready, dest tag 3.
        step(1, 0, 1, 0, 0, 0, 1);
        step(1, 0, 1, 0, 0, 0, 2);
        step(1, 1, 0, 2, 3, 4, 0);

        // Same-cycle assign and commit of tag 3: bypass on src2.
        step(1, 1, 1, 3, 4, 5, 3);
        step(1, 0, 0, 4, 5, 0, 0);

        // dest 0 consumes nothing; duplicate commit of tag 0 is ignored.
        step(1, 1, 0, 1, 2, 0, 0);
        step(1, 0, 1, 1, 0, 0, 0);
        step(1, 0, 1, 1, 0, 0, 0);
        step(1, 1, 0, 1, 5, 6, 0);

        // Exhaust the free list from a clean state.
        step(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++)
            step(1, 1, 0, $urandom_range(31), $urandom_range(31), 1 + (i % 31), 0);
        step(1, 1, 0, 1, 2, 7, 0);          // empty: no allocation
        step(1, 1, 1, 3, 4, 8, 17);         // freed tag not yet allocatable
        step(1, 1, 0, 5, 6, 9, 0);          // now gets tag 17

        // Remap arch 5 twice; committing the older tag leaves it busy.
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 5, 0);          // tag 0
        step(1, 1, 0, 5, 0, 5, 0);          // tag 1, src reads tag 0
        step(1, 0, 1, 5, 5, 0, 0);
        step(1, 0, 0, 5, 0, 0, 0);          // still busy with tag 1
        step(1, 0, 1, 5, 0, 0, 1);
        step(1, 0, 0, 5, 5, 0, 0);          // released

        // Random traffic with occasional reset.
        for (int i = 0; i < 600; i++) begin
            c = ($urandom_range(3) != 0) ? pick_inflight() : -1;
            if (c < 0) c = $urandom_range(31);
            step(($urandom_range(99) != 0), ($urandom_range(2) != 0),
                 ($urandom_range(1) != 0),
                 $urandom_range(31), $urandom_range(31), $urandom_range(31), c);
        end

        @(posedge clk);
        #1;
        assign_flag = 1'b0;
        return_flag = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
